// File: rtl/rfsoc_cfg_serializer.sv
// Serial configuration shifter: shifts a parallel word MSB-first onto cfg_lines[0] while
// toggling only the selected serial clock line. Optional even-parity bit: RFSOC_CFG_SER_PARITY_EN.
module rfsoc_cfg_serializer #(
    parameter int DATA_W    = 32,
    parameter int CLK_DIV   = 4,
    parameter int NUM_LINES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [7:0]           in_target,
    output logic [NUM_LINES-1:0] cfg_lines,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
`ifdef RFSOC_CFG_SER_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int BCNT_W = $clog2(NBITS + 1);
    localparam int PH_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PH_W-1:0]   PH_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [BCNT_W-1:0] BCNT_N  = BCNT_W'(NBITS);
    localparam logic [BCNT_W-1:0] BCNT_1  = BCNT_W'(1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t               state, state_nxt;
    logic [NBITS-1:0]     shreg, shreg_nxt, load_word;
    logic [7:0]           tgt, tgt_nxt;
    logic [PH_W-1:0]      phase, phase_nxt;
    logic [BCNT_W-1:0]    bcnt, bcnt_nxt;
    logic [NUM_LINES-1:0] lines_nxt;
    logic                 done_nxt, err_nxt;
    logic                 tgt_ok, ph_last;

    // Line image for one phase: data bit on line 0, clock level only on the target line.
    function automatic logic [NUM_LINES-1:0] line_image(input logic d, input logic c,
                                                        input logic [7:0] t);
        logic [NUM_LINES-1:0] v;
        v    = '0;
        v[0] = d;
        for (int i = 1; i < NUM_LINES; i++)
            if (t == 8'(i)) v[i] = c;
        return v;
    endfunction

    assign tgt_ok   = (in_target != 8'd0) && ({24'd0, in_target} < 32'(NUM_LINES));
    assign ph_last  = (phase == PH_LAST);
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

`ifdef RFSOC_CFG_SER_PARITY_EN
    assign load_word = {in_data, ^in_data};
`else
    assign load_word = in_data;
`endif

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        tgt_nxt   = tgt;
        phase_nxt = phase;
        bcnt_nxt  = bcnt;
        lines_nxt = cfg_lines;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (tgt_ok) begin
                        state_nxt = LOW;
                        shreg_nxt = load_word;
                        tgt_nxt   = in_target;
                        phase_nxt = '0;
                        bcnt_nxt  = BCNT_N;
                        lines_nxt = line_image(load_word[NBITS-1], 1'b0, in_target);
                    end else begin
                        // Rejected command is consumed; lines stay quiet.
                        err_nxt = 1'b1;
                    end
                end
            end
            LOW: begin
                if (ph_last) begin
                    state_nxt = HIGH;
                    phase_nxt = '0;
                    lines_nxt = line_image(shreg[NBITS-1], 1'b1, tgt);
                end else begin
                    phase_nxt = phase + 1'b1;
                end
            end
            HIGH: begin
                if (ph_last) begin
                    phase_nxt = '0;
                    bcnt_nxt  = bcnt - BCNT_1;
                    if (bcnt == BCNT_1) begin
                        state_nxt = IDLE;
                        shreg_nxt = '0;
                        tgt_nxt   = '0;
                        bcnt_nxt  = '0;
                        lines_nxt = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        // Next data bit changes on the same edge the clock falls.
                        state_nxt = LOW;
                        shreg_nxt = shreg << 1;
                        lines_nxt = line_image(shreg_nxt[NBITS-1], 1'b0, tgt);
                    end
                end else begin
                    phase_nxt = phase + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                lines_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            tgt       <= '0;
            phase     <= '0;
            bcnt      <= '0;
            cfg_lines <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            tgt       <= tgt_nxt;
            phase     <= phase_nxt;
            bcnt      <= bcnt_nxt;
            cfg_lines <= lines_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end
endmodule

// File: tb/tb_rfsoc_cfg_serializer.sv
// Randomized self-checking bench for rfsoc_cfg_serializer against a per-cycle waveform model.
module tb_rfsoc_cfg_serializer;
    localparam int DW = 8;
    localparam int CD = 2;
    localparam int NL = 4;
`ifdef RFSOC_CFG_SER_PARITY_EN
    localparam int NB = DW + 1;
`else
    localparam int NB = DW;
`endif
    localparam int T = 2 * CD * NB + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [7:0]    in_target = '0;
    logic [NL-1:0] cfg_lines;
    logic          busy, done, err;

    int checks = 0;
    int failures = 0;

    rfsoc_cfg_serializer #(.DATA_W(DW), .CLK_DIV(CD), .NUM_LINES(NL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_target(in_target), .cfg_lines(cfg_lines),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Expected {cfg_lines, busy, done, err, in_ready} in cycle c after a valid accept at cycle 0.
    function automatic logic [NL+3:0] exp_vec(input logic [DW-1:0] w, input int t, input int c);
        logic [NL-1:0] l;
        int k, ph;
        l = '0;
        if (c >= 1 && c < T) begin
            k  = (c - 1) / (2 * CD);
            ph = (c - 1) % (2 * CD);
            l[0] = (k < DW) ? w[DW-1-k] : ^w;
            if (ph >= CD) l[t] = 1'b1;
            return {l, 1'b1, 1'b0, 1'b0, 1'b0};
        end
        if (c == T) return {l, 1'b0, 1'b1, 1'b0, 1'b1};
        return {l, 1'b0, 1'b0, 1'b0, 1'b1};
    endfunction

    function automatic logic [NL+3:0] obs_vec();
        return {cfg_lines, busy, done, err, in_ready};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({cfg_lines, busy, done, err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=%b", {cfg_lines, busy, done, err}, {(NL+3){1'b0}});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_vec() !== exp_vec('0, 1, 0)) begin
            failures++;
            $display("FAIL reset_release got=%b want=%b", obs_vec(), exp_vec('0, 1, 0));
        end
    endtask

    task automatic test_shift(input logic [DW-1:0] w, input int t, input bit scramble, input string name);
        int pulses;
        logic prev;
        pulses = 0;
        prev = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = w; in_target = 8'(t);
        for (int c = 1; c <= T; c++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec(w, t, c)) begin
                failures++;
                $display("FAIL %s cycle=%0d got=%b want=%b", name, c, obs_vec(), exp_vec(w, t, c));
            end
            if (cfg_lines[t] && !prev) pulses++;
            prev = cfg_lines[t];
            if (scramble && c < T - 1) begin
                in_valid = 1'($urandom); in_data = DW'($urandom); in_target = 8'($urandom);
            end else begin
                in_valid = 1'b0;
            end
        end
        checks++;
        if (pulses != NB) begin
            failures++;
            $display("FAIL %s_pulses got=%0d want=%0d", name, pulses, NB);
        end
    endtask

    task automatic test_invalid_target(input logic [7:0] t);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL invalid_ready0 target=%0d got=%b want=1", t, in_ready);
        end
        in_valid = 1'b1; in_data = DW'($urandom); in_target = t;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (obs_vec() !== {{NL{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL invalid_err target=%0d got=%b want=%b", t, obs_vec(),
                     {{NL{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b1});
        end
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== exp_vec('0, 1, 0)) begin
                failures++;
                $display("FAIL invalid_quiet target=%0d cycle=%0d got=%b want=%b", t, c, obs_vec(),
                         exp_vec('0, 1, 0));
            end
        end
    endtask

    task automatic test_back_to_back(input logic [DW-1:0] w1, input logic [DW-1:0] w2, input int t);
        int pulses;
        logic prev;
        logic [NL+3:0] e;
        pulses = 0;
        prev = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = w1; in_target = 8'(t);
        for (int c = 1; c <= 2 * T; c++) begin
            @(negedge clk);
            e = (c <= T) ? exp_vec(w1, t, c) : exp_vec(w2, t, c - T);
            checks++;
            if (obs_vec() !== e) begin
                failures++;
                $display("FAIL b2b cycle=%0d got=%b want=%b", c, obs_vec(), e);
            end
            if (cfg_lines[t] && !prev) pulses++;
            prev = cfg_lines[t];
            if (c == 1) in_data = w2;
            if (c == T + 1) in_valid = 1'b0;
        end
        checks++;
        if (pulses != 2 * NB) begin
            failures++;
            $display("FAIL b2b_pulses got=%0d want=%0d", pulses, 2 * NB);
        end
    endtask

    task automatic test_reset_mid_shift();
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hA5; in_target = 8'd1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (obs_vec() !== exp_vec(8'hA5, 1, c)) begin
                failures++;
                $display("FAIL midrst_pre cycle=%0d got=%b want=%b", c, obs_vec(), exp_vec(8'hA5, 1, c));
            end
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({cfg_lines, busy, done, err} !== '0) begin
            failures++;
            $display("FAIL midrst_async got=%b want=%b", {cfg_lines, busy, done, err}, {(NL+3){1'b0}});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_vec() !== exp_vec('0, 1, 0)) begin
            failures++;
            $display("FAIL midrst_release got=%b want=%b", obs_vec(), exp_vec('0, 1, 0));
        end
        test_shift(8'h3C, 2, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_shift(8'hA5, 1, 1'b0, "basic");
        test_invalid_target(8'd0);
        test_invalid_target(8'd4);
        test_invalid_target(8'($urandom_range(5, 255)));
        test_back_to_back(8'hFF, 8'h00, 3);
        test_reset_mid_shift();
        for (int i = 0; i < 6; i++)
            test_shift(DW'($urandom), $urandom_range(1, NL - 1), 1'b1, "ignore_busy");
        test_shift(8'hA5, 2, 1'b0, "par_a5");
        test_shift(8'h01, 2, 1'b0, "par_01");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rfsoc_cfg_serializer.md
# rfsoc_cfg_serializer

Serial configuration shifter downstream of the RFSoC controller's configuration-register selector codes. It accepts a parallel word and a target line index, then bit-bangs the word onto the shared serial data line while toggling only the selected register's serial clock. Line index 0 is the shared data line `sdata`. Line index 1 and upward are per-register serial clocks; index 1 is `mask_clk`, the waveform masking register clock.

## Interface
- `DATA_W`, 32: bits shifted per transaction (≥1).
- `CLK_DIV`, 4: system cycles per serial-clock half period (≥1).
- `NUM_LINES`, 2: width of the output line bus; bit 0 = `sdata`, bits 1..NUM_LINES-1 = serial clocks (≥2).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: command present.
- `in_ready` out 1: block can accept a command.
- `in_data` in DATA_W: word to shift, MSB first.
- `in_target` in 8: line index of the clock to toggle (8-bit, same width as controller selector codes).
- `cfg_lines` out NUM_LINES: bit 0 serial data, bits ≥1 serial clocks.
- `busy` out 1: shift in progress.
- `done` out 1: one-cycle pulse on successful completion.
- `err` out 1: one-cycle pulse on a rejected command.

## Operation
- FSM states: IDLE, LOW, HIGH.
  - IDLE → LOW on accept with a valid target.
  - LOW → HIGH after CLK_DIV cycles.
  - HIGH → LOW after CLK_DIV cycles while bits remain.
  - HIGH → IDLE after the last bit.
- Accept condition: `in_valid && in_ready`. `in_ready` = (state == IDLE).
- Valid target: 1 ≤ `in_target` ≤ NUM_LINES-1.
- Invalid target (0, or ≥ NUM_LINES):
  - Command is consumed.
  - No line moves.
  - `err` pulses the next cycle; `done` stays low.
  - State stays IDLE.
- On accept, latch into a shift register and a target register. All lines are driven from registers.
- LOW phase: `cfg_lines[0]` = current bit; `cfg_lines[target]` = 0.
- HIGH phase: same data bit; `cfg_lines[target]` = 1.
- Non-target clock bits are always 0. The data bit is held constant across its LOW and HIGH phases.
- Bit count N = DATA_W, or DATA_W+1 with parity enabled. The bit counter is `$clog2(N+1)` wide. The phase counter counts 0..CLK_DIV-1.
- On HIGH → IDLE, all lines return to 0 and `done` pulses in the same cycle.
- `busy` = (state != IDLE).
- `in_data` and `in_target` are ignored while busy.
- Reset (asynchronous, any time, including mid-shift):
  - State forced to IDLE.
  - `cfg_lines` = 0, `busy` = 0, `done` = 0, `err` = 0.
  - Counters and shift register cleared.
  - `in_ready` = 1 once reset is released.
  - A partial word is abandoned; nothing is resumed.

## Timing
- Accept edge = cycle 0. Output registers update on edges.
- Bit k (k = 0 first, MSB first):
  - LOW phase: cycles 2·CLK_DIV·k+1 .. 2·CLK_DIV·k+CLK_DIV.
  - HIGH phase: the following CLK_DIV cycles.
- Completion cycle T = 2·CLK_DIV·N+1:
  - `done` = 1, lines = 0, `in_ready` = 1.
  - A command presented in cycle T is accepted, and its first bit appears at T+1. Back-to-back commands have zero idle gap.
- Invalid command accepted in cycle 0: `err` = 1 in cycle 1, `in_ready` stays 1 throughout.
- Data setup to clock rising edge = CLK_DIV cycles. Hold after clock falling edge = 0 cycles; data changes in the same cycle the clock falls.

## Configuration
- `RFSOC_CFG_SER_PARITY_EN` defined:
  - One extra bit is shifted after the LSB, so N = DATA_W+1.
  - The extra bit is even parity: XOR of all `in_data` bits.
  - It is clocked identically to data bits.
- Undefined: N = DATA_W, and no parity logic is present.

## Test plan
- Params used: DATA_W=8, CLK_DIV=2, NUM_LINES=4, parity off.
- **Basic shift:** `in_data`=0xA5, `in_target`=1.
  - `cfg_lines[0]` sequence is 1,0,1,0,0,1,0,1.
  - `cfg_lines[1]` makes 8 high pulses of 2 cycles each; bits 2–3 stay 0.
  - `done` = 1 only at cycle 33; `busy` = 1 for cycles 1–32.
- **Invalid target:** `in_target`=0, then `in_target`=4.
  - Each gives `err` = 1 at cycle 1.
  - `cfg_lines` stays 0, `done` stays 0, `in_ready` stays 1.
- **Back-to-back:** `in_valid` held, words 0xFF then 0x00 to target 3.
  - Second word accepted at cycle 33; its first LOW phase is at cycle 34.
  - `cfg_lines[3]` makes 16 total pulses.
  - `done` pulses at cycles 33 and 66.
- **Reset mid-shift:** assert `rst` at cycle 10 of a 0xA5 transfer.
  - `cfg_lines` = 0 and `busy` = 0 immediately, without waiting for a clock edge.
  - After release, `in_ready` = 1 and a fresh 0x3C transfer shifts correctly.
- **Ignore while busy:** change `in_data` and `in_target` during a transfer.
  - The shifted bits and the toggled clock line are unaffected.
- **Parity build:** with `RFSOC_CFG_SER_PARITY_EN` defined, shift 0xA5 then 0x01 to target 2.
  - 9 clock pulses each.
  - Ninth data bit is 0 for 0xA5 and 1 for 0x01.
  - `done` at cycle 37.
